// File: rtl/reg_bank_sb.sv
// General-purpose register bank: two combinational read ports with flags and
// write-through bypass, one write-back port, and a per-register outstanding-write scoreboard.
module reg_bank_sb #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [SELW-1:0]  iRdAddrA,
    input  logic [SELW-1:0]  iRdAddrB,
    output logic [WIDTH-1:0] oRdDataA,
    output logic [WIDTH-1:0] oRdDataB,
    output logic [2:0]       oFlagsA,
    output logic [2:0]       oFlagsB,
    output logic             oBusyA,
    output logic             oBusyB,
    input  logic             iIssueValid,
    input  logic [SELW-1:0]  iIssueDst,
    input  logic             iWrEnable,
    input  logic [SELW-1:0]  iWrAddr,
    input  logic [1:0]       iWrSrc,
    input  logic [WIDTH-1:0] iInm,
    input  logic [WIDTH:0]   iAlu,
    input  logic [WIDTH-1:0] iMem,
    output logic             oOverflow,
    output logic             oUnderflow
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [WIDTH-1:0] data_q  [NREGS];
    logic [NREGS-1:0] carry_q;
    logic [CNTW-1:0]  count_q [NREGS];
    logic [CNTW-1:0]  count_nxt [NREGS];

    logic             wr_active;
    logic [WIDTH-1:0] wr_data;
    logic             wr_carry;
    logic             ovf_any;
    logic             unf_any;
    logic             bypass_a;
    logic             bypass_b;
    logic             rd_carry_a;
    logic             rd_carry_b;

    function automatic logic [2:0] flags_of(input logic c, input logic [WIDTH-1:0] d);
        return {c, d[WIDTH-1], (d == '0)};
    endfunction

    // Source 11 retires the scoreboard entry without touching data or carry.
    assign wr_active = iWrEnable && (iWrSrc != 2'b11);

    always_comb begin
        wr_data  = iMem;
        wr_carry = 1'b0;
        case (iWrSrc)
            2'b00:   wr_data = iInm;
            2'b01: begin
                wr_data  = iAlu[WIDTH-1:0];
                wr_carry = iAlu[WIDTH];
            end
            default: wr_data = iMem;
        endcase
    end

    assign bypass_a   = wr_active && (iWrAddr == iRdAddrA);
    assign bypass_b   = wr_active && (iWrAddr == iRdAddrB);
    assign oRdDataA   = bypass_a ? wr_data  : data_q[iRdAddrA];
    assign oRdDataB   = bypass_b ? wr_data  : data_q[iRdAddrB];
    assign rd_carry_a = bypass_a ? wr_carry : carry_q[iRdAddrA];
    assign rd_carry_b = bypass_b ? wr_carry : carry_q[iRdAddrB];
    assign oFlagsA    = flags_of(rd_carry_a, oRdDataA);
    assign oFlagsB    = flags_of(rd_carry_b, oRdDataB);

    // A last outstanding write landing this cycle already clears busy, unless re-issued.
    assign oBusyA = (count_q[iRdAddrA] != '0) &&
                    !(bypass_a && (count_q[iRdAddrA] == CNT_ONE) &&
                      !(iIssueValid && (iIssueDst == iRdAddrA)));
    assign oBusyB = (count_q[iRdAddrB] != '0) &&
                    !(bypass_b && (count_q[iRdAddrB] == CNT_ONE) &&
                      !(iIssueValid && (iIssueDst == iRdAddrB)));

    always_comb begin
        ovf_any = 1'b0;
        unf_any = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            logic inc;
            logic dec;
            inc          = iIssueValid && (iIssueDst == SELW'(r));
            dec          = iWrEnable && (iWrAddr == SELW'(r));
            count_nxt[r] = count_q[r];
            if (inc && !dec) begin
                if (count_q[r] == CNT_MAX) ovf_any = 1'b1;
                else count_nxt[r] = count_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                if (count_q[r] == '0) unf_any = 1'b1;
                else count_nxt[r] = count_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r]  <= '0;
                count_q[r] <= '0;
            end
            carry_q    <= '0;
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            if (wr_active) begin
                data_q[iWrAddr]  <= wr_data;
                carry_q[iWrAddr] <= wr_carry;
            end
            for (int r = 0; r < NREGS; r++) count_q[r] <= count_nxt[r];
            oOverflow  <= ovf_any;
            oUnderflow <= unf_any;
        end
    end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised general-purpose register bank for the pipelined uP core, replacing the fixed pair of single 8-bit RPG registers with NREGS registers of WIDTH bits. Provides two asynchronous read ports with per-register flags, one write-back port with immediate/ALU/memory source select, same-cycle write-through bypass, and a per-register outstanding-write scoreboard. Sits between ID (reads, issue) and WB (write-back, retire). The scoreboard lets the hazard logic stall dependent instructions.

## Interface

Parameters:
- WIDTH, 8, data width of each register.
- NREGS, 4, number of registers (power of two).
- SELW, 2, register address width; must equal log2(NREGS).
- CNTW, 2, scoreboard counter width; maximum of 2^CNTW-1 outstanding writes per register.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iRdAddrA  in  SELW  read port A register address.
- iRdAddrB  in  SELW  read port B register address.
- oRdDataA  out  WIDTH  read port A data.
- oRdDataB  out  WIDTH  read port B data.
- oFlagsA  out  3  {C,N,Z} of register A.
- oFlagsB  out  3  {C,N,Z} of register B.
- oBusyA  out  1  register A has an outstanding write.
- oBusyB  out  1  register B has an outstanding write.
- iIssueValid  in  1  an instruction writing iIssueDst enters the pipe.
- iIssueDst  in  SELW  destination register of the issued instruction.
- iWrEnable  in  1  write-back/retire strobe.
- iWrAddr  in  SELW  write-back destination.
- iWrSrc  in  2  00 = iInm, 01 = iAlu, 10 = iMem, 11 = retire without write (squashed).
- iInm  in  WIDTH  immediate data.
- iAlu  in  WIDTH+1  ALU result; bit WIDTH is the carry.
- iMem  in  WIDTH  memory read data.
- oOverflow  out  1  registered one-cycle pulse: issue was rejected because the counter was saturated.
- oUnderflow  out  1  registered one-cycle pulse: retire occurred with a zero count.

## Operation

- Storage: data[NREGS][WIDTH], carry[NREGS], count[NREGS][CNTW].
- Write, when iWrEnable=1 and iWrSrc≠11, at the clock edge:
  - data[iWrAddr] gets the selected source.
  - carry[iWrAddr] gets iAlu[WIDTH] for source 01, otherwise 0.
- iWrSrc=11: data and carry are unchanged; the scoreboard is still retired.
- Flags per register:
  - Z = (data==0).
  - N = data[WIDTH-1].
  - C = stored carry.
- Read is combinational. If iWrEnable=1, iWrSrc≠11 and iWrAddr equals the read address, the port returns the incoming write value and its derived flags (write-through).
- Scoreboard, per register r, at the clock edge:
  - inc = iIssueValid and iIssueDst==r.
  - dec = iWrEnable and iWrAddr==r.
  - inc and dec both true: count is unchanged.
  - inc only: count+1. If the count is already at 2^CNTW-1, it holds and oOverflow=1 next cycle.
  - dec only: count-1. If the count is already 0, it holds and oUnderflow=1 next cycle.
- Busy: oBusyX = (count[iRdAddrX]≠0) and not (a write-through to that register this cycle with count==1 and no issue to it).
- Out-of-range addresses cannot occur, because NREGS = 2^SELW.

## Timing

- Reset, synchronous, one cycle:
  - All data=0 and carry=0.
  - All counts=0.
  - oOverflow=0 and oUnderflow=0.
  - Reads therefore return 0 with flags {C,N,Z}=3'b001 and busy=0.
- Reset has priority over issue and write in the same cycle. A reset asserted mid-operation discards every outstanding count.
- Read latency is 0 cycles (combinational, including bypass). A write is visible through bypass in the same cycle and from storage on the next cycle.
- Scoreboard updates take effect on the edge: busy rises in the cycle after an issue.
- oOverflow and oUnderflow are high for exactly one cycle per offending event.

## Test plan

- Reset, then read all registers: data=0, flags=001, busy=0. Overflow and underflow pulses stay 0.
- Write r2 from iAlu=9'h1FF (WIDTH=8), read A=r2 in the same cycle:
  - Same cycle (bypass): data=8'hFF, flags C=1 N=1 Z=0.
  - Next cycle: identical values from storage.
- Write r1 from iInm=0, then write r1 from iMem=8'h80:
  - After the first write: flags 001.
  - After the second write: data 8'h80, flags 010 (carry cleared on non-ALU source).
- Issue r3 three times, then issue r3 again (CNTW=2):
  - After the three issues: busy=1, count 3.
  - Fourth issue: rejected, count stays 3, oOverflow pulses once.
  - Three retires: busy drops the cycle after the third retire.
- Retire r0 with count 0 and iWrSrc=11: data unchanged, oUnderflow pulses once. Simultaneous issue and retire of r1 with count 1 leaves the count at 1.
- Issue r2 twice, assert Reset for one cycle, then read r2: busy=0, data=0, no pulses, write with Reset high ignored.
